// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one asynchronous-read distributed memory between an
// instruction-fetch port and a read/write data port, one access per three cycles.
module mem_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_d,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_spo,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  // Requester identity: 0 = instruction fetch, 1 = data port.
  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_DM = 1'b1;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_grant_q, last_grant_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic                grant_dm;

  // Data port wins when it is the only requester, or on a tie when fetch was served last.
  assign grant_dm = dm_req && (!if_req || (last_grant_q == OWNER_IF));

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;

    case (state_q)
      IDLE: begin
        if (if_req || dm_req) begin
          state_d      = ACCESS;
          owner_d      = grant_dm ? OWNER_DM : OWNER_IF;
          last_grant_d = grant_dm ? OWNER_DM : OWNER_IF;
          addr_d       = grant_dm ? dm_addr : if_addr;
          wdata_d      = grant_dm ? dm_wdata : '0;
          we_d         = grant_dm && dm_we;
        end
      end
      ACCESS: begin
        state_d = ACK;
        if (!we_q) begin
          if (owner_q == OWNER_DM) begin
            dm_rdata_d = mem_spo;
          end else begin
            if_rdata_d = mem_spo;
          end
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= OWNER_IF;
      last_grant_q <= OWNER_DM;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
    end
  end

  // Memory port is only driven during ACCESS; reset gates the write strobe immediately.
  assign mem_a    = (state_q == ACCESS) ? addr_q  : '0;
  assign mem_d    = (state_q == ACCESS) ? wdata_q : '0;
  assign mem_we   = (state_q == ACCESS) && we_q && !reset;

  assign if_ack   = (state_q == ACK) && (owner_q == OWNER_IF);
  assign dm_ack   = (state_q == ACK) && (owner_q == OWNER_DM);
  assign if_rdata = if_rdata_q;
  assign dm_rdata = dm_rdata_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a behavioural distributed memory plus a linear
// sequence of requests with hand-computed expectations.
module tb_mem_arbiter;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 16;

  logic              clk;
  logic              reset;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ack;
  logic [DATA_W-1:0] dm_rdata;
  logic [ADDR_W-1:0] mem_a;
  logic [DATA_W-1:0] mem_d;
  logic              mem_we;
  logic [DATA_W-1:0] mem_spo;
  logic              busy;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_ack   (if_ack),
    .if_rdata (if_rdata),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_ack   (dm_ack),
    .dm_rdata (dm_rdata),
    .mem_a    (mem_a),
    .mem_d    (mem_d),
    .mem_we   (mem_we),
    .mem_spo  (mem_spo),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_spo = mem[mem_a];

  always @(posedge clk) begin
    if (mem_we) mem[mem_a] <= mem_d;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
      $display("check %-22s observed=%h expected=%h ok", tag, obs, exp);
    end else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
    mem[5] = 16'h1234;
    mem[3] = 16'h0333;
    mem[9] = 16'h0999;
    mem[2] = 16'h2222;

    reset = 1'b1; if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    tick(); tick();

    // Reset state
    chk("rst_busy",     {31'd0, busy},    32'd0);
    chk("rst_if_ack",   {31'd0, if_ack},  32'd0);
    chk("rst_dm_ack",   {31'd0, dm_ack},  32'd0);
    chk("rst_if_rdata", {16'd0, if_rdata}, 32'd0);
    chk("rst_dm_rdata", {16'd0, dm_rdata}, 32'd0);
    chk("rst_mem_we",   {31'd0, mem_we},  32'd0);
    chk("rst_mem_a",    {21'd0, mem_a},   32'd0);
    reset = 1'b0;

    // Fetch of preloaded word 5: presented here, ack two edges later
    if_req = 1'b1; if_addr = 11'd5;
    tick();
    chk("f_access_busy",  {31'd0, busy},   32'd1);
    chk("f_access_mem_a", {21'd0, mem_a},  32'd5);
    chk("f_access_we",    {31'd0, mem_we}, 32'd0);
    chk("f_access_ack",   {31'd0, if_ack}, 32'd0);
    tick();
    chk("f_ack",          {31'd0, if_ack},   32'd1);
    chk("f_rdata",        {16'd0, if_rdata}, 32'h1234);
    chk("f_dm_ack",       {31'd0, dm_ack},   32'd0);
    chk("f_ack_mem_a",    {21'd0, mem_a},    32'd0);
    if_req = 1'b0;
    tick();
    chk("f_idle_ack",     {31'd0, if_ack},   32'd0);
    chk("f_idle_busy",    {31'd0, busy},     32'd0);
    chk("f_rdata_held",   {16'd0, if_rdata}, 32'h1234);

    // Data write to top address, then read it back
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 11'h7FF; dm_wdata = 16'hBEEF;
    tick();
    chk("w_mem_we",       {31'd0, mem_we}, 32'd1);
    chk("w_mem_a",        {21'd0, mem_a},  32'h7FF);
    chk("w_mem_d",        {16'd0, mem_d},  32'hBEEF);
    tick();
    chk("w_ack_mem_we",   {31'd0, mem_we},   32'd0);
    chk("w_dm_ack",       {31'd0, dm_ack},   32'd1);
    chk("w_if_ack",       {31'd0, if_ack},   32'd0);
    chk("w_rdata_kept",   {16'd0, dm_rdata}, 32'd0);
    dm_we = 1'b0;
    tick();
    chk("r_idle_ack",     {31'd0, dm_ack}, 32'd0);
    tick();
    chk("r_mem_we",       {31'd0, mem_we}, 32'd0);
    chk("r_mem_a",        {21'd0, mem_a},  32'h7FF);
    tick();
    chk("r_dm_ack",       {31'd0, dm_ack},   32'd1);
    chk("r_dm_rdata",     {16'd0, dm_rdata}, 32'hBEEF);
    dm_req = 1'b0;
    tick();

    // Round-robin after reset: fetch wins first tie, then alternates
    reset = 1'b1; tick(); reset = 1'b0;
    if_req = 1'b1; if_addr = 11'd5; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 11'h7FF;
    for (int n = 0; n < 4; n++) begin
      tick(); tick();
      chk($sformatf("rr%0d_if_ack", n), {31'd0, if_ack}, (n % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("rr%0d_dm_ack", n), {31'd0, dm_ack}, (n % 2 == 1) ? 32'd1 : 32'd0);
      tick();
    end
    if_req = 1'b0; dm_req = 1'b0;
    chk("rr_if_rdata", {16'd0, if_rdata}, 32'h1234);
    chk("rr_dm_rdata", {16'd0, dm_rdata}, 32'hBEEF);
    tick();

    // Address latched at grant: change mid-access must not retarget
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 11'd3;
    tick();
    dm_addr = 11'd9;
    #1;
    chk("latch_mem_a", {21'd0, mem_a}, 32'd3);
    tick();
    chk("latch_rdata", {16'd0, dm_rdata}, 32'h0333);
    dm_req = 1'b0;
    tick();

    // Reset during a write access aborts it
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 11'd2; dm_wdata = 16'hAAAA;
    tick();
    chk("abort_pre_we", {31'd0, mem_we}, 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_we_gated", {31'd0, mem_we}, 32'd0);
    tick();
    reset = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    chk("abort_dm_ack",   {31'd0, dm_ack},   32'd0);
    chk("abort_busy",     {31'd0, busy},     32'd0);
    chk("abort_mem_a",    {21'd0, mem_a},    32'd0);
    chk("abort_dm_rdata", {16'd0, dm_rdata}, 32'd0);
    chk("abort_if_rdata", {16'd0, if_rdata}, 32'd0);
    chk("abort_mem2",     {16'd0, mem[2]},   32'h2222);
    tick();
    chk("abort_no_ack",   {31'd0, dm_ack},   32'd0);

    // Fetch arriving during a data write waits; if_ack trails dm_ack by 3 cycles
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 11'd4; dm_wdata = 16'h4444;
    tick();
    if_req = 1'b1; if_addr = 11'd4;
    tick();
    chk("wait_dm_ack", {31'd0, dm_ack}, 32'd1);
    chk("wait_if_ack", {31'd0, if_ack}, 32'd0);
    dm_req = 1'b0; dm_we = 1'b0;
    tick();
    chk("wait_idle_if_ack", {31'd0, if_ack}, 32'd0);
    chk("wait_idle_busy",   {31'd0, busy},   32'd0);
    tick();
    chk("wait_acc_if_ack",  {31'd0, if_ack}, 32'd0);
    chk("wait_acc_mem_a",   {21'd0, mem_a},  32'd4);
    tick();
    chk("wait_if_ack_late", {31'd0, if_ack},   32'd1);
    chk("wait_if_rdata",    {16'd0, if_rdata}, 32'h4444);
    if_req = 1'b0;
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
